// File: rtl/reduction_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : reduction_checker_if
// Brief    : Bundles the run control, stimulus vector, observed reduction
//            results and status outputs of reduction_checker.
// Revision : 1.0
// ============================================================================
interface reduction_checker_if;
    logic       start;
    logic [7:0] seed;
    logic [7:0] in_vector;
    logic       out_and;
    logic       out_or;
    logic       out_nand;
    logic       out_nor;
    logic       out_xor;
    logic       out_nxor;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] vec_count;
    logic [7:0] first_fail_vector;

    // master: the checker itself; slave: the environment around it
    modport master (
        input  start, seed,
        input  out_and, out_or, out_nand, out_nor, out_xor, out_nxor,
        output in_vector, busy, done, pass, err_count, vec_count, first_fail_vector
    );

    modport slave (
        output start, seed,
        output out_and, out_or, out_nand, out_nor, out_xor, out_nxor,
        input  in_vector, busy, done, pass, err_count, vec_count, first_fail_vector
    );
endinterface
`default_nettype wire

// File: rtl/reduction_checker.sv
`default_nettype none
// ============================================================================
// Module   : reduction_checker
// Brief    : Drives a vector sequence into a reduction-operator DUT and
//            checks its six reduction outputs against locally computed values.
// Revision : 1.0
// ============================================================================
module reduction_checker #(
    parameter int NUM_VECTORS = 16,
    parameter int SETTLE      = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    reduction_checker_if.master bus
);
    localparam logic [7:0] C_LAST_IDX  = 8'(NUM_VECTORS - 1);
    localparam logic [3:0] C_WAIT_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_accept;
    logic       w_check;
    logic       w_last;

    logic [3:0] r_wait_cnt;
    logic [7:0] r_vec;
    logic [7:0] r_seed;
    logic [7:0] r_err;
    logic [7:0] r_vcnt;
    logic [7:0] r_ffv;
    logic       r_pass;

    logic [7:0] w_lfsr;
    logic [7:0] w_next_vec;
    logic [5:0] w_exp;
    logic [5:0] w_act;
    logic       w_mismatch;
    logic [7:0] w_err_nxt;

    assign w_last = (r_vcnt == C_LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_check     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_wait_cnt == C_WAIT_LAST) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                w_check     = 1'b1;
                w_state_nxt = w_last ? DONE : WAIT;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_lfsr = {r_vec[6:0], r_vec[7] ^ r_vec[5] ^ r_vec[4] ^ r_vec[3]};

    // The first two vectors are fixed corner cases; the LFSR takes over from v2.
    always_comb begin
        w_next_vec = w_lfsr;
        if (r_vcnt == 8'd0) begin
            w_next_vec = 8'hFF;
        end else if (r_vcnt == 8'd1) begin
            w_next_vec = r_seed;
        end
    end

    assign w_exp      = {&r_vec, |r_vec, ~&r_vec, ~|r_vec, ^r_vec, ~^r_vec};
    assign w_act      = {bus.out_and, bus.out_or, bus.out_nand,
                         bus.out_nor, bus.out_xor, bus.out_nxor};
    assign w_mismatch = (w_exp != w_act);
    assign w_err_nxt  = r_err + {7'd0, w_mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
            r_vec      <= 8'd0;
            r_seed     <= 8'd0;
            r_err      <= 8'd0;
            r_vcnt     <= 8'd0;
            r_ffv      <= 8'd0;
            r_pass     <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + 4'd1 : 4'd0;
            if (w_accept) begin
                r_vec  <= 8'h00;
                r_seed <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
                r_err  <= 8'd0;
                r_vcnt <= 8'd0;
                r_ffv  <= 8'd0;
                r_pass <= 1'b0;
            end else if (w_check) begin
                r_vcnt <= r_vcnt + 8'd1;
                r_err  <= w_err_nxt;
                if (w_mismatch && (r_err == 8'd0)) begin
                    r_ffv <= r_vec;
                end
                // Pass is resolved on entry to DONE so it is valid alongside done.
                if (w_last) begin
                    r_pass <= (w_err_nxt == 8'd0);
                end else begin
                    r_vec <= w_next_vec;
                end
            end
        end
    end

    assign bus.in_vector         = r_vec;
    assign bus.busy              = (r_state != IDLE);
    assign bus.done              = (r_state == DONE);
    assign bus.pass              = r_pass;
    assign bus.err_count         = r_err;
    assign bus.vec_count         = r_vcnt;
    assign bus.first_fail_vector = r_ffv;
endmodule
`default_nettype wire

// File: doc/reduction_checker.md
REDUCTION_CHECKER -- requirements
Module: reduction_checker

Interface
REQ-001 Parameters SHALL be:
- NUM_VECTORS, default 16: vectors per run, legal range 2..255.
- SETTLE, default 2: wait cycles after each drive before sampling, legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 seed  input  8  LFSR seed; captured on accepted start.
REQ-006 in_vector  output  8  registered vector driven to the reduction DUT.
REQ-007 out_and, out_or, out_nand, out_nor, out_xor, out_nxor  input  1 each  DUT reduction results.
REQ-008 busy  output  1  high from accepted start until the DONE cycle, inclusive.
REQ-009 done  output  1  one-cycle pulse at end of run.
REQ-010 pass  output  1  high when the last completed run had zero mismatches.
REQ-011 err_count  output  8  mismatching vectors in the current or last run.
REQ-012 vec_count  output  8  vectors checked in the current or last run.
REQ-013 first_fail_vector  output  8  first mismatching vector; 0 if none.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, CHECK, DONE.
REQ-015 Accepted start (IDLE, start=1):
- in_vector loads vector 0 and the seed is captured.
- err_count, vec_count, first_fail_vector and pass clear.
- busy rises; next state is WAIT.
REQ-016 start seen outside IDLE SHALL be ignored, with no effect on the running sequence.
REQ-017 WAIT SHALL last exactly SETTLE cycles, then go to CHECK.
REQ-018 CHECK SHALL last one cycle. At its closing edge:
- Outputs are compared against expected values.
- vec_count increments.
- Next vector loads and state returns to WAIT; after vector NUM_VECTORS-1 it goes to DONE instead.
REQ-019 Each vector SHALL occupy SETTLE+1 cycles. done SHALL be high in the cycle beginning NUM_VECTORS*(SETTLE+1) edges after the start edge.
REQ-020 Vector sequence:
- v0 = 8'h00, v1 = 8'hFF, v2 = seed.
- Seed 8'h00 is replaced by 8'h01.
- v(k+1) = {v(k)[6:0], v(k)[7]^v(k)[5]^v(k)[4]^v(k)[3]}.
REQ-021 Expected values SHALL be &v, |v, ~&v, ~|v, ^v and ~^v of the vector currently on in_vector.
REQ-022 Any single differing output SHALL count as one mismatch for that vector:
- err_count increments by 1 per mismatching vector, not per output.
- first_fail_vector captures only the first mismatch of the run.
REQ-023 DONE SHALL last one cycle, with done=1 and busy=1:
- pass is set to (err_count==0).
- Next state is IDLE.
- in_vector holds the last vector.
REQ-024 pass, err_count, vec_count and first_fail_vector SHALL hold after DONE until the next accepted start.
REQ-025 A start asserted during DONE SHALL be ignored; start held high into the following IDLE cycle SHALL be accepted.
REQ-026 DUT inputs SHALL be sampled only at the CHECK closing edge; values during WAIT have no effect.

Reset
REQ-027 rst_n low SHALL immediately force:
- state IDLE;
- in_vector, err_count, vec_count, first_fail_vector = 0;
- busy, done, pass = 0.
REQ-028 Reset mid-run SHALL abort the run with no done pulse. A start after rst_n release SHALL restart from v0.
REQ-029 While rst_n is low, start SHALL be ignored.

Verification
REQ-030 Correct DUT model, SETTLE=2, NUM_VECTORS=16, seed 8'hA5 -> done 48 cycles after start edge; pass=1, err_count=0, vec_count=16, first_fail_vector=0.
REQ-031 DUT with out_xor stuck 0, seed 8'h01 -> v0 and v1 pass, v2=8'h01 fails; first_fail_vector=8'h01, pass=0, err_count>=1.
REQ-032 DUT with all six outputs inverted, NUM_VECTORS=16 -> err_count=16, first_fail_vector=8'h00, pass=0.
REQ-033 seed 8'h00 -> in_vector during v2 = 8'h01 and v3 = 8'h02.
REQ-034 rst_n pulsed low during WAIT of vector 5 -> all outputs 0 at once, no done; a new start reruns from v0 and gives vec_count=16 at done.
REQ-035 start pulsed again while busy, and during DONE -> no restart; done pulses exactly once; counts unaffected.
